// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width: counts 0..width-1
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_1_bit.sv
// One-bit full adder cell, the only arithmetic in the serial adder.
module full_adder_1_bit (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    logic p;

    assign p    = A ^ B;
    assign S    = p ^ CIN;
    assign COUT = (A & B) | (CIN & p);

endmodule

// File: rtl/serial_adder_8_bits.sv
// Bit-serial adder: S = A + B + CIN computed LSB first, one bit per clock,
// with a start/busy/done handshake.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the OVF output
// (signed two's-complement overflow of the completed result).
module serial_adder_8_bits
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             CIN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_nxt;

    full_adder_1_bit u_fa (
        .A    (a_reg[0]),
        .B    (b_reg[0]),
        .CIN  (carry),
        .S    (fa_s),
        .COUT (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB
    assign sum_nxt = {fa_s, {(WIDTH-1){1'b0}}} | (sum_reg >> 1);

    // Control FSM, operand/sum shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            S       <= '0;
            COUT    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            OVF     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        carry   <= CIN;
                        sum_reg <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_reg <= sum_nxt;
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    carry   <= fa_cout;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        S     <= sum_nxt;
                        COUT  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry register holds the carry into the MSB here
                        OVF   <= carry ^ fa_cout;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_8_bits.sv
// Self-checking bench for serial_adder_8_bits: directed and random operations
// compared against a plain-arithmetic reference.
module tb_serial_adder_8_bits;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         CIN;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] S;
    logic         COUT;
    logic         busy;
    logic         done;
`ifdef SERIAL_ADDER_OVF_EN
    logic         OVF;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_s;

    serial_adder_8_bits #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .CIN   (CIN),
        .A     (A),
        .B     (B),
        .S     (S),
        .COUT  (COUT),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned addition, signed overflow from operand/result signs
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        s  = full[W-1:0];
        co = full[W];
        ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // Launch one operation, optionally poke start mid-operation, check result and timing
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input bit pulse, input string tag);
        logic [W-1:0] es;
        logic         eco, eov;
        int           n;
        bit           seen;
        model(a, b, ci, es, eco, eov);
        @(negedge clk);
        A = a; B = b; CIN = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); CIN = 1'($urandom);
        check({tag, ".busy_after_start"}, busy, 1);
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
            else if (n == 4) check({tag, ".s_hold_midop"}, S, prev_s);
            if (pulse && n == 3) begin
                start = 1'b1; A = ~a; B = a; CIN = ~ci;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, ".latency"}, n, W);
        check({tag, ".S"}, S, es);
        check({tag, ".COUT"}, COUT, eco);
        check({tag, ".busy_in_done"}, busy, 1);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".OVF"}, OVF, eov);
`endif
        @(posedge clk); #1;
        check({tag, ".done_one_cycle"}, done, 0);
        check({tag, ".busy_cleared"}, busy, 0);
        if (pulse) begin
            // A start seen while busy must not have been queued
            repeat (3) @(posedge clk);
            #1;
            check({tag, ".no_queued_op"}, busy, 0);
            check({tag, ".result_kept"}, S, es);
        end
        prev_s = es;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] es1, es2;
        logic         eco1, eco2, eov;
        int           n;
        bit           seen;

        rst = 1'b1; start = 1'b0; CIN = 1'b0; A = '0; B = '0;
        prev_s = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.S", S, 0);
        check("reset.COUT", COUT, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset.OVF", OVF, 0);
`endif

        do_op(8'hFF, 8'h00, 1'b0, 0, "ff_plus_0");
        do_op(8'h0F, 8'h02, 1'b0, 0, "0f_plus_02");
        do_op(8'h3C, 8'h0A, 1'b1, 0, "3c_plus_0a_c1");
        do_op(8'hFF, 8'h01, 1'b0, 0, "wrap_carry");
        do_op(8'h92, 8'hF9, 1'b1, 1, "subtract_busy_pulse");
        do_op(8'h7F, 8'h01, 1'b0, 0, "signed_ovf");
        do_op(8'h80, 8'h80, 1'b0, 0, "neg_ovf");

        // Reset during the 4th SHIFT cycle aborts with everything cleared
        @(negedge clk);
        A = 8'hAB; B = 8'h55; CIN = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset.S", S, 0);
        check("midreset.COUT", COUT, 0);
        check("midreset.busy", busy, 0);
        check("midreset.done", done, 0);
        prev_s = '0;
        do_op(8'h12, 8'h34, 1'b0, 0, "after_reset");

        // Random operations
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 0, "random");
        end

        // Held start relaunches on the next IDLE cycle with the operands present then
        model(8'h5A, 8'hC3, 1'b0, es1, eco1, eov);
        model(8'h21, 8'h9E, 1'b1, es2, eco2, eov);
        @(negedge clk);
        A = 8'h5A; B = 8'hC3; CIN = 1'b0; start = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        A = 8'h21; B = 8'h9E; CIN = 1'b1;
        check("held.first_S", S, es1);
        check("held.first_COUT", COUT, eco1);
        n = 0; seen = 0;
        while (!seen && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        check("held.relaunch_gap", n, W + 2);
        check("held.second_S", S, es2);
        check("held.second_COUT", COUT, eco2);
        repeat (12) @(posedge clk);
        #1;
        check("held.stopped", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
